// File: rtl/uart_rx_fifo_ram.sv
// Byte storage for the receive FIFO: one synchronous write port and one
// asynchronous read port, shaped so it maps onto distributed RAM.
module uart_rx_fifo_ram #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  i_Clock,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [7:0]            wr_data,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [7:0]            rd_data
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [7:0] mem [DEPTH];

   // Contents are deliberately left unreset so the array stays RAM-inferable.
   always_ff @(posedge i_Clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: buffers bytes from the receiver, presents the head byte
// first-word-fall-through, and reports fill level, overrun and interrupt.
module uart_rx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int IRQ_LEVEL  = 1
) (
   input  logic                  i_Clock,
   input  logic                  reset,
   input  logic                  i_Rx_DV,
   input  logic [7:0]            i_Rx_Byte,
   input  logic                  i_Rd,
   input  logic                  i_Flush,
   input  logic                  i_Clr_Ovr,
   output logic [7:0]            o_Data,
   output logic                  o_Empty,
   output logic                  o_Full,
   output logic [DEPTH_LOG2:0]   o_Count,
   output logic                  o_Overrun,
   output logic                  o_Irq
);

   localparam int PTR_W = DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overrun;
   logic [7:0]       ram_data;
   logic             do_push;
   logic             do_pop;
   logic             drop;
   logic             wr_en;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
   always_comb begin
      do_pop  = i_Rd && (count != '0);
      do_push = i_Rx_DV && ((count != CNT_W'(DEPTH)) || do_pop);
      drop    = i_Rx_DV && !do_push;
      wr_en   = do_push && !i_Flush && !reset;
   end

   always_ff @(posedge i_Clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (i_Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
               count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
               count <= count - 1'b1;
            end
         end
         // A fresh overrun outranks a clear arriving in the same cycle.
         if (drop) begin
            overrun <= 1'b1;
         end else if (i_Clr_Ovr) begin
            overrun <= 1'b0;
         end
      end
   end

   uart_rx_fifo_ram #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_ram (
      .i_Clock (i_Clock),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (i_Rx_Byte),
      .rd_addr (rd_ptr),
      .rd_data (ram_data)
   );

   assign o_Empty   = (count == '0);
   assign o_Full    = (count == CNT_W'(DEPTH));
   assign o_Count   = count;
   assign o_Overrun = overrun;
   assign o_Irq     = (count >= CNT_W'(IRQ_LEVEL));
   assign o_Data    = o_Empty ? 8'h00 : ram_data;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DLOG = 4;
   localparam int DEPTH = 1 << DLOG;
   localparam int IRQ = 3;

   logic            i_Clock = 1'b0;
   logic            reset = 1'b1;
   logic            i_Rx_DV = 1'b0;
   logic [7:0]      i_Rx_Byte = 8'h00;
   logic            i_Rd = 1'b0;
   logic            i_Flush = 1'b0;
   logic            i_Clr_Ovr = 1'b0;
   logic [7:0]      o_Data;
   logic            o_Empty;
   logic            o_Full;
   logic [DLOG:0]   o_Count;
   logic            o_Overrun;
   logic            o_Irq;

   int vectors = 0;
   int miscompares = 0;

   byte unsigned model_q[$];
   bit           model_ovr = 1'b0;

   typedef struct {
      bit       dv;
      bit [7:0] data_in;
      bit       rd;
      int       exp_count;
      bit [7:0] exp_data;
   } vec_t;

   vec_t table_v[8];

   uart_rx_fifo #(
      .DEPTH_LOG2(DLOG),
      .IRQ_LEVEL (IRQ)
   ) dut (
      .i_Clock   (i_Clock),
      .reset     (reset),
      .i_Rx_DV   (i_Rx_DV),
      .i_Rx_Byte (i_Rx_Byte),
      .i_Rd      (i_Rd),
      .i_Flush   (i_Flush),
      .i_Clr_Ovr (i_Clr_Ovr),
      .o_Data    (o_Data),
      .o_Empty   (o_Empty),
      .o_Full    (o_Full),
      .o_Count   (o_Count),
      .o_Overrun (o_Overrun),
      .o_Irq     (o_Irq)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic checkValue(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference behaviour expressed directly as queue operations.
   task automatic modelUpdate(input bit rst, input bit dv, input bit [7:0] b,
                              input bit rd, input bit fl, input bit clr);
      bit pop;
      bit full;
      if (rst) begin
         model_q.delete();
         model_ovr = 1'b0;
      end else begin
         pop  = rd && (model_q.size() > 0);
         full = (model_q.size() == DEPTH);
         if (fl) begin
            model_q.delete();
         end else begin
            if (pop) void'(model_q.pop_front());
            if (dv && (!full || pop)) model_q.push_back(b);
         end
         if (dv && full && !pop) model_ovr = 1'b1;
         else if (clr) model_ovr = 1'b0;
      end
   endtask

   task automatic checkOutput();
      int n;
      n = model_q.size();
      checkValue("count", int'(o_Count), n);
      checkValue("data", int'(o_Data), (n > 0) ? int'(model_q[0]) : 0);
      checkValue("empty", int'(o_Empty), int'(n == 0));
      checkValue("full", int'(o_Full), int'(n == DEPTH));
      checkValue("irq", int'(o_Irq), int'(n >= IRQ));
      checkValue("overrun", int'(o_Overrun), int'(model_ovr));
   endtask

   task automatic applyStimulus(input bit rst, input bit dv, input bit [7:0] b,
                                input bit rd, input bit fl, input bit clr);
      reset     = rst;
      i_Rx_DV   = dv;
      i_Rx_Byte = b;
      i_Rd      = rd;
      i_Flush   = fl;
      i_Clr_Ovr = clr;
      @(posedge i_Clock);
      modelUpdate(rst, dv, b, rd, fl, clr);
      #1;
      reset     = 1'b0;
      i_Rx_DV   = 1'b0;
      i_Rx_Byte = 8'h00;
      i_Rd      = 1'b0;
      i_Flush   = 1'b0;
      i_Clr_Ovr = 1'b0;
      checkOutput();
   endtask

   task automatic push(input bit [7:0] b);
      applyStimulus(1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      table_v[0] = '{1'b1, 8'h41, 1'b0, 1, 8'h41};
      table_v[1] = '{1'b0, 8'h00, 1'b0, 1, 8'h41};
      table_v[2] = '{1'b1, 8'h42, 1'b0, 2, 8'h41};
      table_v[3] = '{1'b0, 8'h00, 1'b0, 2, 8'h41};
      table_v[4] = '{1'b1, 8'h43, 1'b0, 3, 8'h41};
      table_v[5] = '{1'b0, 8'h00, 1'b1, 2, 8'h42};
      table_v[6] = '{1'b0, 8'h00, 1'b1, 1, 8'h43};
      table_v[7] = '{1'b0, 8'h00, 1'b1, 0, 8'h00};

      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      checkValue("reset_empty", int'(o_Empty), 1);

      // In-order delivery with one-cycle latency.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, table_v[i].dv, table_v[i].data_in, table_v[i].rd, 1'b0, 1'b0);
         checkValue("tbl_count", int'(o_Count), table_v[i].exp_count);
         checkValue("tbl_data", int'(o_Data), int'(table_v[i].exp_data));
      end
      checkValue("tbl_empty", int'(o_Empty), 1);

      // Fill past capacity: 17th byte is dropped and flagged.
      for (int i = 0; i < 17; i++) begin
         push(8'(i));
         if (i == 15) checkValue("full_after_16", int'(o_Full), 1);
         if (i == 15) checkValue("no_ovr_at_16", int'(o_Overrun), 0);
      end
      checkValue("ovr_after_17", int'(o_Overrun), 1);
      for (int i = 0; i < 16; i++) begin
         checkValue("drain_data", int'(o_Data), i);
         pop();
      end
      checkValue("drain_empty", int'(o_Empty), 1);

      // Full FIFO with simultaneous push and pop.
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checkValue("ovr_cleared", int'(o_Overrun), 0);
      for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
      applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      checkValue("full_pp_count", int'(o_Count), 16);
      checkValue("full_pp_ovr", int'(o_Overrun), 0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) checkValue("aa_last", int'(o_Data), 8'hAA);
         pop();
      end

      // Empty FIFO with simultaneous push and pop, then a pop on empty.
      applyStimulus(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      checkValue("empty_pp_count", int'(o_Count), 1);
      checkValue("empty_pp_data", int'(o_Data), 8'h55);
      pop();
      pop();
      checkValue("underflow_count", int'(o_Count), 0);
      checkValue("underflow_ovr", int'(o_Overrun), 0);

      // Flush overrides a concurrent push.
      for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
      applyStimulus(1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      checkValue("flush_count", int'(o_Count), 0);
      checkValue("flush_empty", int'(o_Empty), 1);
      push(8'h12);
      checkValue("post_flush_data", int'(o_Data), 8'h12);
      pop();

      // Overrun set beats clear; clear alone works; reset mid-fill.
      for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
      applyStimulus(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      checkValue("set_beats_clr", int'(o_Overrun), 1);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checkValue("clr_alone", int'(o_Overrun), 0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
      applyStimulus(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
      checkValue("rst_count", int'(o_Count), 0);
      checkValue("rst_data", int'(o_Data), 0);
      checkValue("rst_irq", int'(o_Irq), 0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 2000; i++) begin
         applyStimulus($urandom_range(0, 299) == 0,
                       $urandom_range(0, 99) < 55,
                       8'($urandom),
                       $urandom_range(0, 99) < 45,
                       $urandom_range(0, 99) < 2,
                       $urandom_range(0, 99) < 5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
